// File: rtl/iobuf_turnaround_ctrl.sv
// ---------------------------------------------------------------------------
// iobuf_turnaround_ctrl : half-duplex tristate bus sequencer with turnaround gaps
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iobuf_turnaround_ctrl #(
  parameter int WIDTH         = 8,
  parameter int TURN_CYCLES   = 2,
  parameter int DRIVE_CYCLES  = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN_ON = 3'd1,
    DRIVE   = 3'd2,
    RELEASE = 3'd3,
    SAMPLE  = 3'd4
  } state_t;

  localparam logic [7:0] TURN_LOAD   = 8'(TURN_CYCLES - 1);
  localparam logic [7:0] DRIVE_LOAD  = 8'(DRIVE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       read_first;
  logic       released;
  logic       grant_wr;
  logic       grant_rd;

  // On contention the side that was not granted last time wins.
  assign grant_wr = wr_req && (!rd_req || !read_first);
  assign grant_rd = rd_req && (!wr_req ||  read_first);

  assign pad_t = {WIDTH{released}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      read_first <= 1'b0;
      released   <= 1'b1;
      pad_i      <= '0;
      rd_data    <= '0;
      wr_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            pad_i      <= wr_data;
            cnt        <= TURN_LOAD;
            read_first <= 1'b1;
            busy       <= 1'b1;
            state      <= TURN_ON;
          end else if (grant_rd) begin
            cnt        <= SETTLE_LOAD;
            read_first <= 1'b0;
            busy       <= 1'b1;
            state      <= SAMPLE;
          end
        end
        TURN_ON: begin
          if (cnt == 8'd0) begin
            released <= 1'b0;
            cnt      <= DRIVE_LOAD;
            state    <= DRIVE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DRIVE: begin
          if (cnt == 8'd0) begin
            released <= 1'b1;
            wr_ack   <= 1'b1;
            cnt      <= TURN_LOAD;
            state    <= RELEASE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RELEASE: begin
          if (cnt == 8'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SAMPLE: begin
          if (cnt == 8'd0) begin
            rd_data  <= pad_o;
            rd_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          released <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iobuf_turnaround_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iobuf_turnaround_ctrl : directed self-checking bench for iobuf_turnaround_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iobuf_turnaround_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req, rd_req, wr_ack, rd_valid, busy;
  logic [7:0] wr_data, rd_data, pad_i, pad_t, pad_o;
  logic       wr_req2, rd_req2, wr_ack2, rd_valid2, busy2;
  logic [7:0] wr_data2, rd_data2, pad_i2, pad_t2, pad_o2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iobuf_turnaround_ctrl dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .pad_i(pad_i), .pad_t(pad_t), .pad_o(pad_o)
  );

  iobuf_turnaround_ctrl #(.WIDTH(8), .TURN_CYCLES(1), .DRIVE_CYCLES(1), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset),
    .wr_req(wr_req2), .wr_data(wr_data2), .wr_ack(wr_ack2),
    .rd_req(rd_req2), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .busy(busy2), .pad_i(pad_i2), .pad_t(pad_t2), .pad_o(pad_o2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_n;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    wr_req = 0; rd_req = 0; wr_data = 8'h00; pad_o = 8'h00;
    wr_req2 = 0; rd_req2 = 0; wr_data2 = 8'h00; pad_o2 = 8'h00;
    #1;
    chk("rst_pad_t", pad_t, 8'hFF);
    chk("rst_pad_i", pad_i, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    edge_n();
    reset = 1'b0;
    edge_n();

    // Single write A5
    wr_req = 1; wr_data = 8'hA5;
    for (int e = 0; e <= 7; e++) begin
      edge_n();
      chk("wr_pad_i", pad_i, 8'hA5);
      chk("wr_pad_t", pad_t, (e >= 2 && e <= 4) ? 8'h00 : 8'hFF);
      chk("wr_ack", wr_ack, (e == 5) ? 1 : 0);
      chk("wr_busy", busy, (e <= 6) ? 1 : 0);
      if (wr_ack) wr_req = 0;
      wr_data = 8'h5A;
    end

    // Single read 3C
    pad_o = 8'h3C; rd_req = 1;
    for (int e = 0; e <= 3; e++) begin
      edge_n();
      chk("rd_valid", rd_valid, (e == 2) ? 1 : 0);
      chk("rd_pad_t", pad_t, 8'hFF);
      chk("rd_busy", busy, (e <= 1) ? 1 : 0);
      if (e >= 2) chk("rd_data", rd_data, 8'h3C);
      if (rd_valid) rd_req = 0;
    end
    pad_o = 8'h00;

    // Reset during DRIVE
    wr_req = 1; wr_data = 8'hC7;
    for (int e = 0; e <= 3; e++) edge_n();
    chk("drv_pad_t_before", pad_t, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("drv_rst_pad_t", pad_t, 8'hFF);
    chk("drv_rst_pad_i", pad_i, 8'h00);
    chk("drv_rst_busy", busy, 0);
    chk("drv_rst_wr_ack", wr_ack, 0);
    wr_req = 0;
    edge_n();
    chk("drv_rst_hold_wr_ack", wr_ack, 0);
    reset = 1'b0;
    pad_o = 8'hC3; rd_req = 1;
    for (int e = 0; e <= 3; e++) begin
      edge_n();
      chk("post_rst_rd_valid", rd_valid, (e == 2) ? 1 : 0);
      chk("post_rst_wr_ack", wr_ack, 0);
      chk("post_rst_pad_t", pad_t, 8'hFF);
      if (rd_valid) rd_req = 0;
    end
    chk("post_rst_rd_data", rd_data, 8'hC3);

    // Simultaneous requests from reset: W (edges 0-7), R (8-10), W (11-18)
    reset = 1'b1;
    edge_n();
    reset = 1'b0;
    wr_req = 1; rd_req = 1; wr_data = 8'hA1; pad_o = 8'h77;
    for (int e = 0; e <= 19; e++) begin
      edge_n();
      chk("sim_pad_t", pad_t, ((e >= 2 && e <= 4) || (e >= 13 && e <= 15)) ? 8'h00 : 8'hFF);
      chk("sim_wr_ack", wr_ack, (e == 5 || e == 16) ? 1 : 0);
      chk("sim_rd_valid", rd_valid, (e == 10) ? 1 : 0);
      chk("sim_pad_i", pad_i, (e >= 11) ? 8'hB2 : 8'hA1);
      if (e == 0) wr_data = 8'hB2;
      if (e == 18) begin wr_req = 0; rd_req = 0; end
    end
    chk("sim_rd_data", rd_data, 8'h77);

    // TURN=1, DRIVE=1 back-to-back writes 11, 22
    wr_req2 = 1; wr_data2 = 8'h11;
    for (int e = 0; e <= 7; e++) begin
      edge_n();
      chk("b2b_pad_t", pad_t2, (e == 1 || e == 5) ? 8'h00 : 8'hFF);
      chk("b2b_wr_ack", wr_ack2, (e == 2 || e == 6) ? 1 : 0);
      chk("b2b_pad_i", pad_i2, (e >= 4) ? 8'h22 : 8'h11);
      if (e == 2) wr_data2 = 8'h22;
      if (e == 6) wr_req2 = 0;
    end
    chk("b2b_busy_end", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iobuf_turnaround_ctrl.md
# iobuf_turnaround_ctrl

Sequencer and arbiter for a WIDTH-bit bank of tristate I/O buffer cells on a shared half-duplex bus. The block sits between a write requester and a read requester and the buffer bank's I/T/O pins. It owns the T (tristate-enable) line and inserts guaranteed turnaround gaps, so the pad is never driven while the far end may still be driving. Typical placement is between a PicoBlaze port decoder and an external bidirectional data bus.

## Interface
Parameters:
- WIDTH, 8, bus width in bits.
- TURN_CYCLES, 2, released-bus cycles inserted before and after every drive window (legal 1..255).
- DRIVE_CYCLES, 3, cycles the pad is actively driven per write (legal 1..255).
- SETTLE_CYCLES, 2, cycles from read acceptance to sampling of pad_o (legal 1..255).

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- wr_req, input, 1, write request; level, held until wr_ack.
- wr_data, input, WIDTH, write data; captured on the acceptance edge.
- wr_ack, output, 1, one-cycle pulse when the write's drive window has ended.
- rd_req, input, 1, read request; level, held until rd_valid.
- rd_data, output, WIDTH, sampled bus value; holds until the next read completes.
- rd_valid, output, 1, one-cycle pulse, rd_data is new.
- busy, output, 1, high whenever state is not IDLE.
- pad_i, output, WIDTH, to the buffer I pins.
- pad_t, output, WIDTH, to the buffer T pins; all bits are identical; 1 means released (high-Z).
- pad_o, input, WIDTH, from the buffer O pins.

## Operation
- Reset (asynchronous, immediate):
  - pad_t = all ones, pad_i = 0, rd_data = 0.
  - wr_ack = rd_valid = busy = 0.
  - state = IDLE, counter = 0, priority flag = write-first.
- States: IDLE, TURN_ON, DRIVE, RELEASE, SAMPLE. 8-bit down-counter cnt.
- IDLE: pad_t = 1. Requests are sampled only in IDLE.
  - wr_req only: pad_i <= wr_data; cnt <= TURN_CYCLES-1; go to TURN_ON.
  - rd_req only: cnt <= SETTLE_CYCLES-1; go to SAMPLE.
  - Both high: grant the side opposite to the last grant. After reset the write side wins. Each grant toggles the priority flag to the other side, so service alternates strictly.
- TURN_ON: pad_t = 1. When cnt = 0: pad_t <= 0, cnt <= DRIVE_CYCLES-1, go to DRIVE; otherwise decrement cnt.
- DRIVE: pad_t = 0, pad_i stable. When cnt = 0: pad_t <= 1, wr_ack <= 1, cnt <= TURN_CYCLES-1, go to RELEASE.
- RELEASE: pad_t = 1, wr_ack for the first cycle only. When cnt = 0, go to IDLE.
- SAMPLE: pad_t = 1. When cnt = 0: rd_data <= pad_o, rd_valid <= 1, go to IDLE.
- pad_t is never 0 outside DRIVE. pad_i changes only on write acceptance.
- Requests that drop before being serviced are ignored. A request that is still high in IDLE after its own ack/valid is treated as a new request; requesters must deassert on ack.
- Reset asserted mid-operation aborts the transfer with no ack or valid; pad_t releases the same cycle reset rises.

## Timing
- Write accepted at edge 0:
  - pad_t low from edge TURN_CYCLES to edge TURN_CYCLES+DRIVE_CYCLES.
  - wr_ack is high for the cycle after edge TURN_CYCLES+DRIVE_CYCLES.
  - IDLE after edge 2·TURN_CYCLES+DRIVE_CYCLES; the next acceptance is one edge later.
- Read accepted at edge 0: rd_data/rd_valid update at edge SETTLE_CYCLES; IDLE at the same edge; the next acceptance is at edge SETTLE_CYCLES+1.
- Minimum released time between any two drive windows is 2·TURN_CYCLES+1 cycles.
- busy rises on the acceptance edge and falls on the edge that enters IDLE.

## Test plan
- Reset: assert reset mid-cycle -> pad_t = FF, pad_i = 00, busy/wr_ack/rd_valid = 0, with no clock edge required.
- Single write, defaults, wr_data = A5 accepted at edge 0 -> pad_i = A5 after edge 0; pad_t = 00 after edges 2-4 and FF after edge 5; wr_ack high only after edge 5; busy = 0 after edge 7.
- Single read, pad_o = 3C, accepted at edge 0 -> rd_data = 3C and rd_valid high for exactly the one cycle after edge 2; pad_t = FF throughout.
- Simultaneous wr_req and rd_req held high after reset -> grants alternate write, read, write; pad_t never low during SAMPLE; exactly one wr_ack per write and one rd_valid per read.
- Reset during DRIVE (edge 3 of a write) -> pad_t = FF immediately; no wr_ack; after release, state IDLE and a new read completes normally.
- TURN_CYCLES = 1, DRIVE_CYCLES = 1, back-to-back writes 11, 22 -> each drive window is 1 cycle; released gap between windows is 3 cycles; pad_i = 22 only after the second acceptance.
